serial_word_comparator: RTL and testbench

Downstream consumer of the per-bit XNOR equality stage: accepts one equality bit per valid cycle (bit_eq = XNOR of two serial streams) and accumulates a WORD_W-bit frame. At end of frame it reports whole-word equality, a saturating mismatch count, and the index of the first mismatching bit. Sits between the XNOR stage and any checker or LED/display logic in the lab datapath.

---
 rtl/serial_word_comparator.sv | 126 ++++++++++++
 tb/tb_serial_word_comparator.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_comparator.sv
// Collects WORD_W per-bit equality flags from the XNOR stage into a frame and
// reports whole-word equality, a saturating mismatch count and the first mismatch index.
module serial_word_comparator #(
  parameter  int WORD_W = 8,
  parameter  int ERR_W  = 4,
  localparam int IDX_W  = $clog2(WORD_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_eq,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             word_eq,
  output logic [ERR_W-1:0] mismatch_cnt,
  output logic [IDX_W-1:0] first_mismatch_idx
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             all_eq;
  logic [ERR_W-1:0] cnt;
  logic [IDX_W-1:0] first_idx;
  logic             found;

  // Accumulator values as they would stand after consuming the current bit.
  logic             mis;
  logic             last_bit;
  logic             all_eq_nxt;
  logic [ERR_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] first_nxt;
  logic             found_nxt;

  always_comb begin
    mis        = ~bit_eq;
    last_bit   = (idx == LAST_IDX);
    all_eq_nxt = all_eq & bit_eq;
    cnt_nxt    = cnt;
    if (mis && (cnt != {ERR_W{1'b1}}))
      cnt_nxt = cnt + ERR_W'(1);
    first_nxt  = (mis && !found) ? idx : first_idx;
    found_nxt  = found | mis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      ready              <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      word_eq            <= 1'b0;
      mismatch_cnt       <= '0;
      first_mismatch_idx <= '0;
      idx                <= '0;
      all_eq             <= 1'b1;
      cnt                <= '0;
      first_idx          <= '0;
      found              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready     <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          idx       <= '0;
          all_eq    <= 1'b1;
          cnt       <= '0;
          first_idx <= '0;
          found     <= 1'b0;
          // A bit arriving with start is dropped; the frame begins on the next valid bit.
          if (start) begin
            state <= COLLECT;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        COLLECT: begin
          if (start) begin
            idx       <= '0;
            all_eq    <= 1'b1;
            cnt       <= '0;
            first_idx <= '0;
            found     <= 1'b0;
          end else if (bit_valid) begin
            all_eq    <= all_eq_nxt;
            cnt       <= cnt_nxt;
            first_idx <= first_nxt;
            found     <= found_nxt;
            if (last_bit) begin
              state              <= DONE;
              busy               <= 1'b0;
              done               <= 1'b1;
              word_eq            <= all_eq_nxt;
              mismatch_cnt       <= cnt_nxt;
              first_mismatch_idx <= first_nxt;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_comparator.sv
// Randomized self-checking bench for serial_word_comparator: three instances
// (8-bit/4-bit count, 8-bit/2-bit count, 5-bit frame) against a frame-level model.
module tb_serial_word_comparator;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, bit_valid = 1'b0, bit_eq = 1'b0;

  logic r8, b8, d8, e8; logic [3:0] c8; logic [2:0] i8;
  logic r2, b2, d2, e2; logic [1:0] c2; logic [2:0] i2;
  logic r5, b5, d5, e5; logic [3:0] c5; logic [2:0] i5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_word_comparator #(.WORD_W(8), .ERR_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .bit_eq(bit_eq),
    .ready(r8), .busy(b8), .done(d8), .word_eq(e8), .mismatch_cnt(c8), .first_mismatch_idx(i8));

  serial_word_comparator #(.WORD_W(8), .ERR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .bit_eq(bit_eq),
    .ready(r2), .busy(b2), .done(d2), .word_eq(e2), .mismatch_cnt(c2), .first_mismatch_idx(i2));

  serial_word_comparator #(.WORD_W(5), .ERR_W(4)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .bit_eq(bit_eq),
    .ready(r5), .busy(b5), .done(d5), .word_eq(e5), .mismatch_cnt(c5), .first_mismatch_idx(i5));

  // Frame-level reference: count zeros, locate the first one, clamp the count.
  function automatic void model(input logic [63:0] bits, input int n, input int errw,
                                output logic eq, output int cnt, output int idx);
    int zeros = 0;
    int maxc  = (1 << errw) - 1;
    idx = 0;
    for (int i = n - 1; i >= 0; i--)
      if (!bits[i]) begin
        zeros++;
        idx = i;
      end
    eq  = (zeros == 0);
    cnt = (zeros > maxc) ? maxc : zeros;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_done(input int w);
    return (w == 5) ? d5 : (d8 | d2);
  endfunction

  // Optionally pulse start, then feed n bits (index 0 first) with idle gaps.
  // Returns after the edge that consumes the last bit; early flags any done seen before.
  task automatic drive_frame(input bit do_start, input logic [63:0] bits, input int n,
                             input int w, input int max_gap, input logic [63:0] gap_mask,
                             output bit early);
    int g;
    early = 1'b0;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      if (cur_done(w)) early = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_eq    = bits[i];
      tick();
      bit_valid = 1'b0;
      if (i == n - 1) break;
      if (cur_done(w)) early = 1'b1;
      g = gap_mask[i] ? 2 : ((max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
      repeat (g) begin
        bit_eq = 1'($urandom);
        tick();
        if (cur_done(w)) early = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({r8, b8, d8, e8, c8, i8} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL reset_u8: got %b expected %b", {r8, b8, d8, e8, c8, i8}, 11'b1000_0000_000);
    end
    n_cmp++;
    if ({r2, b2, d2, e2, c2, i2, r5, b5, d5, e5, c5, i5} !== {4'b1000, 2'd0, 3'd0, 4'b1000, 4'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL reset_u2_u5: got %b", {r2, b2, d2, e2, c2, i2, r5, b5, d5, e5, c5, i5});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_equal();
    bit early;
    drive_frame(1'b1, 64'hFF, 8, 8, 0, 64'h0, early);
    n_cmp++;
    if ({early, d8, r8, b8, e8, c8, i8} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL all_equal: got early/d/r/b/eq/cnt/idx=%b expected 0100_1_0000_000", {early, d8, r8, b8, e8, c8, i8});
    end
    tick();
    n_cmp++;
    if ({d8, r8, b8} !== 3'b010) begin
      n_bad++;
      $display("FAIL all_equal_idle: got done/ready/busy=%b expected 010", {d8, r8, b8});
    end
  endtask

  task automatic test_gaps();
    bit early;
    // Order 1,1,0,1,0,1,1,1 with two idle cycles after bits 0 and 3.
    drive_frame(1'b1, 64'b1110_1011, 8, 8, 0, 64'h9, early);
    n_cmp++;
    if ({early, d8, e8, c8, i8} !== {1'b0, 1'b1, 1'b0, 4'd2, 3'd2}) begin
      n_bad++;
      $display("FAIL gaps: got early=%b done=%b eq=%b cnt=%0d idx=%0d expected 0 1 0 2 2", early, d8, e8, c8, i8);
    end
    tick();
  endtask

  task automatic test_saturate();
    bit early;
    drive_frame(1'b1, 64'h0, 8, 8, 1, 64'h0, early);
    n_cmp++;
    if ({early, d2, e2, c2, i2} !== {1'b0, 1'b1, 1'b0, 2'd3, 3'd0}) begin
      n_bad++;
      $display("FAIL saturate_u2: got early=%b done=%b eq=%b cnt=%0d idx=%0d expected 0 1 0 3 0", early, d2, e2, c2, i2);
    end
    n_cmp++;
    if ({d8, e8, c8, i8} !== {1'b1, 1'b0, 4'd8, 3'd0}) begin
      n_bad++;
      $display("FAIL saturate_u8: got done=%b eq=%b cnt=%0d idx=%0d expected 1 0 8 0", d8, e8, c8, i8);
    end
    tick();
  endtask

  task automatic test_abort();
    bit early;
    drive_frame(1'b1, 64'b11110, 5, 8, 0, 64'h0, early);
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_eq    = 1'b0;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    n_cmp++;
    if ({early, d8, b8, e8, c8, i8} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 3'd0}) begin
      n_bad++;
      $display("FAIL abort_hold: got early/done/busy/eq/cnt/idx=%b expected 0010_1000_000", {early, d8, b8, e8, c8, i8});
    end
    drive_frame(1'b0, 64'hFF, 8, 8, 1, 64'h0, early);
    n_cmp++;
    if ({early, d8, e8, c8, i8} !== {1'b0, 1'b1, 1'b1, 4'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL abort_restart: got early=%b done=%b eq=%b cnt=%0d idx=%0d expected 0 1 1 0 0", early, d8, e8, c8, i8);
    end
    tick();
  endtask

  task automatic test_start_in_done();
    bit early;
    drive_frame(1'b1, 64'hF7, 8, 8, 0, 64'h0, early);
    n_cmp++;
    if ({early, d8, e8, c8, i8} !== {1'b0, 1'b1, 1'b0, 4'd1, 3'd3}) begin
      n_bad++;
      $display("FAIL done_frame: got early=%b done=%b eq=%b cnt=%0d idx=%0d expected 0 1 0 1 3", early, d8, e8, c8, i8);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({d8, r8, b8} !== 3'b010) begin
      n_bad++;
      $display("FAIL start_in_done: got done/ready/busy=%b expected 010", {d8, r8, b8});
    end
    tick();
    n_cmp++;
    if ({r8, b8, e8, c8, i8} !== {1'b1, 1'b0, 1'b0, 4'd1, 3'd3}) begin
      n_bad++;
      $display("FAIL results_stable: got ready/busy/eq/cnt/idx=%b expected 10_0_0001_011", {r8, b8, e8, c8, i8});
    end
  endtask

  task automatic test_idle_start_valid();
    bit early;
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_eq    = 1'b0;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    drive_frame(1'b0, 64'hFF, 8, 8, 0, 64'h0, early);
    n_cmp++;
    if ({early, d8, e8, c8, i8} !== {1'b0, 1'b1, 1'b1, 4'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL idle_start_valid: got early=%b done=%b eq=%b cnt=%0d idx=%0d expected 0 1 1 0 0", early, d8, e8, c8, i8);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit early;
    drive_frame(1'b1, 64'h0, 3, 8, 0, 64'h0, early);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({r8, b8, d8, e8, c8, i8} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL reset_mid: got %b expected 1000_0000_000", {r8, b8, d8, e8, c8, i8});
    end
    tick();
    rst_n = 1'b1;
    tick();
    drive_frame(1'b1, 64'h7F, 8, 8, 0, 64'h0, early);
    n_cmp++;
    if ({early, d8, e8, c8, i8} !== {1'b0, 1'b1, 1'b0, 4'd1, 3'd7}) begin
      n_bad++;
      $display("FAIL last_bit_mismatch: got early=%b done=%b eq=%b cnt=%0d idx=%0d expected 0 1 0 1 7", early, d8, e8, c8, i8);
    end
    tick();
  endtask

  task automatic test_random();
    bit early;
    logic [7:0] a, b, bits;
    logic eq8, eq2;
    int cnt8, idx8, cnt2, idx2;
    for (int f = 0; f < 100; f++) begin
      a    = 8'($urandom);
      b    = ($urandom_range(3, 0) == 0) ? a : 8'($urandom);
      bits = ~(a ^ b);
      model({56'd0, bits}, 8, 4, eq8, cnt8, idx8);
      model({56'd0, bits}, 8, 2, eq2, cnt2, idx2);
      drive_frame(1'b1, {56'd0, bits}, 8, 8, 2, 64'h0, early);
      n_cmp++;
      if ({early, d8, e8, c8, i8} !== {1'b0, 1'b1, eq8, 4'(cnt8), 3'(idx8)}) begin
        n_bad++;
        $display("FAIL random_u8 frame %0d bits=%b: got early=%b done=%b eq=%b cnt=%0d idx=%0d expected 0 1 %b %0d %0d",
                 f, bits, early, d8, e8, c8, i8, eq8, cnt8, idx8);
      end
      n_cmp++;
      if ({d2, e2, c2, i2} !== {1'b1, eq2, 2'(cnt2), 3'(idx2)}) begin
        n_bad++;
        $display("FAIL random_u2 frame %0d bits=%b: got done=%b eq=%b cnt=%0d idx=%0d expected 1 %b %0d %0d",
                 f, bits, d2, e2, c2, i2, eq2, cnt2, idx2);
      end
      tick();
    end
  endtask

  task automatic test_word5();
    bit early;
    logic [4:0] bits;
    logic eq;
    int cnt, idx;
    for (int f = 0; f < 30; f++) begin
      bits = 5'($urandom) | (($urandom_range(2, 0) == 0) ? 5'h1F : 5'h0);
      model({59'd0, bits}, 5, 4, eq, cnt, idx);
      drive_frame(1'b1, {59'd0, bits}, 5, 5, 1, 64'h0, early);
      n_cmp++;
      if ({early, d5, e5, c5, i5} !== {1'b0, 1'b1, eq, 4'(cnt), 3'(idx)}) begin
        n_bad++;
        $display("FAIL word5 frame %0d bits=%b: got early=%b done=%b eq=%b cnt=%0d idx=%0d expected 0 1 %b %0d %0d",
                 f, bits, early, d5, e5, c5, i5, eq, cnt, idx);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_all_equal();
    test_gaps();
    test_saturate();
    test_abort();
    test_start_in_done();
    test_idle_start_valid();
    test_reset_mid();
    test_random();
    test_word5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
